// File: rtl/shifter_pkg.sv
// Shared encodings and helpers for the iterative shifter/rotator.
package shifter_pkg;

    localparam logic [2:0] MODE_SRL = 3'b000;
    localparam logic [2:0] MODE_SLL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int unsigned min_u(input int unsigned x, input int unsigned y);
        return (x < y) ? x : y;
    endfunction

    // Encodings above ROL carry the operand through unchanged.
    function automatic logic is_pass(input logic [2:0] mode);
        return mode > MODE_ROL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: moves the word by 0..STEP positions per mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int AW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [AW-1:0]   amt_i,
    input  logic [2:0]      mode_i,
    output logic [XLEN-1:0] data_o
);

    logic [2*XLEN-1:0] dbl;

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        data_o = data_i;
        dbl    = {data_i, data_i};
        case (mode_i)
            MODE_SRL: data_o = data_i >> amt_i;
            MODE_SLL: data_o = data_i << amt_i;
            MODE_SRA: data_o = $unsigned($signed(data_i) >>> amt_i);
            MODE_ROR: begin
                dbl    = dbl >> amt_i;
                data_o = dbl[XLEN-1:0];
            end
            MODE_ROL: begin
                dbl    = dbl << amt_i;
                data_o = dbl[2*XLEN-1:XLEN];
            end
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: accepts a request in IDLE, shifts up to STEP
// positions per cycle, then pulses done with the result held on shifted.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [SHW-1:0]  shamt,
    input  logic [2:0]      mode,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] shifted
);

    localparam int AW = $clog2(STEP + 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  count_q, count_d;
    logic [2:0]      mode_q, mode_d;
    logic [XLEN-1:0] shifted_q, shifted_d;

    logic [AW-1:0]   k;
    logic [XLEN-1:0] step_out;

    assign k = AW'(min_u(STEP, 32'(count_q)));

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP),
        .AW   (AW)
    ) u_step (
        .data_i (work_q),
        .amt_i  (k),
        .mode_i (mode_q),
        .data_o (step_out)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from the values present before the edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            count_q   <= '0;
            mode_q    <= MODE_SRL;
            shifted_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            shifted_q <= shifted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (shamt != '0 && !is_pass(mode)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (count_q == SHW'(k)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The result register is loaded only on the transition into DONE, so
    // intermediate work values never reach the output.
    always_comb begin
        work_d    = work_q;
        count_d   = count_q;
        mode_d    = mode_q;
        shifted_d = shifted_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = a;
                    count_d = shamt;
                    mode_d  = mode;
                    if (shamt == '0 || is_pass(mode)) shifted_d = a;
                end
            end
            ST_SHIFT: begin
                work_d  = step_out;
                count_d = count_q - SHW'(k);
                if (count_d == '0) shifted_d = step_out;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE:  ready = 1'b1;
            ST_SHIFT: busy  = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign shifted = shifted_q;

endmodule
